// File: rtl/tx_scheduler_pkg.sv
// tx_pkg: shared states and frame geometry for the transmitter scheduler.
package tx_pkg;
    typedef enum logic [1:0] {RECOVER, IDLE, LAUNCH, BUSY} tx_sched_state_t;
    localparam int FRAME_BYTES = 16;
    localparam int FRAME_W = 128;
    localparam int BAUD_W = 8;
    localparam int FSIZE_W = 4;
endpackage

// File: rtl/tx_scheduler_if.sv
// tx_scheduler_if: scheduler-to-transmitter link; master drives the frame, slave reports TXI.
interface tx_scheduler_if;
    import tx_pkg::*;
    logic tf;
    logic [FSIZE_W-1:0] framesize;
    logic [FRAME_W-1:0] framebits;
    logic [BAUD_W-1:0] baudrate;
    logic TXI;
    modport master (output tf, framesize, framebits, baudrate, input TXI);
    modport slave (input tf, framesize, framebits, baudrate, output TXI);
endinterface

// File: rtl/tx_scheduler_rr_picker.sv
// rr_picker: first asserted request at or after the pointer, wrapping.
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      pointer,
    output logic            valid,
    output logic [NREQ-1:0] win_onehot,
    output logic [2:0]      win_idx
);
    assign valid = |req;
    assign win_onehot = NREQ'(1) << win_idx;
    // Scan farthest-first so the candidate nearest the pointer overrides.
    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(pointer) + k) % NREQ]) win_idx = 3'((int'(pointer) + k) % NREQ);
    end
endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin sharing of one serial transmitter among NREQ frame sources.
module tx_scheduler import tx_pkg::*; #(
    parameter int NREQ = 4,
    parameter int START_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*FSIZE_W-1:0] req_framesize,
    input  logic [NREQ*FRAME_W-1:0] req_framebits,
    input  logic [NREQ*BAUD_W-1:0]  req_baudrate,
    output logic [NREQ-1:0]         grant,
    output logic                    err,
    output logic                    done,
    output logic [2:0]              done_id,
    output logic                    busy,
    tx_scheduler_if.master          tx
);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    tx_sched_state_t r_state, w_next;
    logic [2:0] r_ptr, w_ptr, w_idx;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [NREQ-1:0] r_grant, w_grant, w_onehot;
    logic r_err, w_err, r_done, w_done, r_tf, w_tf, r_busy, w_cap, w_valid, w_bad;
    logic [2:0] r_id;
    logic [FSIZE_W-1:0] r_fs, w_fs;
    logic [FRAME_W-1:0] r_fb, w_fb;
    logic [BAUD_W-1:0] r_bd, w_bd;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .req(req), .pointer(r_ptr), .valid(w_valid), .win_onehot(w_onehot), .win_idx(w_idx)
    );

    assign w_fs = req_framesize[w_idx*FSIZE_W +: FSIZE_W];
    assign w_fb = req_framebits[w_idx*FRAME_W +: FRAME_W];
    assign w_bd = req_baudrate[w_idx*BAUD_W +: BAUD_W];
    assign w_bad = (w_fs == '0) || (w_bd < BAUD_W'(2));

    always_comb begin
        w_next = r_state;
        w_ptr = r_ptr;
        w_cnt = r_cnt;
        w_grant = '0;
        w_err = 1'b0;
        w_done = 1'b0;
        w_tf = r_tf;
        w_cap = 1'b0;
        case (r_state)
            RECOVER: w_next = tx.TXI ? IDLE : RECOVER;
            IDLE: if (w_valid) begin
                w_grant = w_onehot;
                w_cap = 1'b1;
                w_ptr = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 3'd1;
                w_err = w_bad;
                w_tf = !w_bad;
                w_cnt = '0;
                w_next = w_bad ? IDLE : LAUNCH;
            end
            LAUNCH: if (!tx.TXI) begin
                w_tf = 1'b0;
                w_next = BUSY;
            end else if (r_cnt == CW'(START_TIMEOUT - 1)) begin
                w_tf = 1'b0;
                w_err = 1'b1;
                w_next = IDLE;
            end else w_cnt = r_cnt + 1'b1;
            BUSY: if (tx.TXI) begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = RECOVER;
        endcase
    end

    // The transmitter has no reset, so clearing tf here is what keeps it from relaunching.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RECOVER;
            r_ptr <= '0;
            r_cnt <= '0;
            r_grant <= '0;
            r_err <= 1'b0;
            r_done <= 1'b0;
            r_tf <= 1'b0;
            r_busy <= 1'b1;
            r_id <= '0;
            r_fs <= '0;
            r_fb <= '0;
            r_bd <= '0;
        end else begin
            r_state <= w_next;
            r_ptr <= w_ptr;
            r_cnt <= w_cnt;
            r_grant <= w_grant;
            r_err <= w_err;
            r_done <= w_done;
            r_tf <= w_tf;
            r_busy <= (w_next != IDLE);
            if (w_cap) begin
                r_id <= w_idx;
                r_fs <= w_fs;
                r_fb <= w_fb;
                r_bd <= w_bd;
            end
        end
    end

    assign grant = r_grant;
    assign err = r_err;
    assign done = r_done;
    assign done_id = r_id;
    assign busy = r_busy;
    assign tx.tf = r_tf;
    assign tx.framesize = r_fs;
    assign tx.framebits = r_fb;
    assign tx.baudrate = r_bd;
endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: scheduler beside a behavioural transmitter; scoreboard of grant/err/done events.
module tb_tx_scheduler;
    import tx_pkg::*;
    localparam int K_GOK = 0, K_GERR = 1, K_DONE = 2, K_TMO = 3;
    typedef struct {int kind; int id; logic [127:0] fb;} ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [3:0] req = '0;
    logic [15:0] req_framesize = '0;
    logic [511:0] req_framebits = '0;
    logic [31:0] req_baudrate = '0;
    logic [3:0] grant;
    logic err, done, busy;
    logic [2:0] done_id;
    tx_scheduler_if txif();

    tx_scheduler #(.NREQ(4), .START_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_framesize(req_framesize),
        .req_framebits(req_framebits), .req_baudrate(req_baudrate), .grant(grant),
        .err(err), .done(done), .done_id(done_id), .busy(busy), .tx(txif)
    );

    always #5 clk = ~clk;

    // Transmitter model: TXI low for all but the stop bit; flags any drift of its live inputs.
    logic disc = 1'b0;
    logic m_txi = 1'b1;
    logic m_bad = 1'b0;
    int m_left = 0;
    logic [127:0] m_fb = '0;
    logic [3:0] m_fs = '0;
    logic [7:0] m_bd = '0;
    assign txif.TXI = disc ? 1'b1 : m_txi;

    always @(posedge clk) begin
        if (!disc && m_txi && txif.tf) begin
            m_txi <= 1'b0;
            m_left <= (14 + 8 * int'(txif.framesize)) * int'(txif.baudrate) - int'(txif.baudrate);
            m_fb <= txif.framebits;
            m_fs <= txif.framesize;
            m_bd <= txif.baudrate;
            m_bad <= 1'b0;
        end else if (!m_txi) begin
            if (txif.framebits != m_fb || txif.framesize != m_fs || txif.baudrate != m_bd) m_bad <= 1'b1;
            if (m_left <= 1) m_txi <= 1'b1;
            m_left <= m_left - 1;
        end
    end

    int n_chk = 0, n_pass = 0;
    ev_t q[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push(input int kind, input int id, input logic [127:0] fb);
        ev_t e;
        e.kind = kind;
        e.id = id;
        e.fb = fb;
        q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [3:0] fs, input logic [7:0] bd, input logic [127:0] fb);
        req_framesize[i*4 +: 4] = fs;
        req_baudrate[i*8 +: 8] = bd;
        req_framebits[i*128 +: 128] = fb;
        req[i] = 1'b1;
    endtask

    task automatic wait_grant(input int i);
        int n = 0;
        while (!grant[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!grant[i]) begin
            n_chk++;
            $display("FAIL grant_timeout: no grant for requester %0d, required one", i);
        end
    endtask

    task automatic wait_q_empty(input int lim);
        int n = 0;
        while (q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL events_pending: %0d outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: every grant/err/done pulse is matched against the next expected event.
    int cyc = 0, tf_rise = 0, tf_w = 0, n_tf = 0, last_done = -1, last_grant = -1, kind;
    logic prev_tf = 1'b0;
    logic b2b = 1'b0;
    ev_t e;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset_n) prev_tf = 1'b0;
        else begin
            if (txif.tf && !prev_tf) begin
                tf_rise = cyc;
                n_tf++;
            end
            if (!txif.tf && prev_tf) tf_w = cyc - tf_rise;
            prev_tf = txif.tf;
            if (grant != '0 || done || err) begin
                kind = grant != '0 ? (err ? K_GERR : K_GOK) : (done ? K_DONE : K_TMO);
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_event: got kind %0d id %0d, required none", kind, done_id);
                end else begin
                    e = q.pop_front();
                    check("event_kind", kind, e.kind);
                    check("done_id", done_id, e.id);
                    if (kind <= K_GERR) begin
                        check("grant_onehot", grant, 4'(1) << e.id);
                        check("tf_with_grant", txif.tf, kind == K_GOK);
                        if (b2b && last_done > last_grant) check("b2b_gap", cyc - last_done, 1);
                        last_grant = cyc;
                    end else if (kind == K_DONE) begin
                        check("frame_bits", m_fb, e.fb);
                        check("data_stable", m_bad, 1'b0);
                        check("tf_width", tf_w, 2);
                        check("busy_after_done", busy, 1'b0);
                        last_done = cyc;
                    end else begin
                        check("timeout_delay", cyc - tf_rise, 15);
                        check("tf_off_timeout", txif.tf, 1'b0);
                        check("busy_off_timeout", busy, 1'b0);
                    end
                end
            end
        end
    end

    initial begin
        int bad, n, tf0;
        logic [127:0] fb_d;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b1);
        check("rst_tf", txif.tf, 1'b0);
        check("rst_grant", grant, 4'b0);
        check("rst_framebits", txif.framebits, 128'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // All four continuously requesting: strict rotation 0,1,2,3,0.
        b2b = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 4'd2, 8'd2, {4{32'hC0DE_0000 | 32'(i)}});
        for (int r = 0; r < 5; r++) begin
            push(K_GOK, r % 4, '0);
            push(K_DONE, r % 4, {4{32'hC0DE_0000 | 32'(r % 4)}});
        end
        for (int r = 0; r < 5; r++) begin
            wait_grant(r % 4);
            @(negedge clk);
        end
        req = '0;
        wait_q_empty(1000);
        b2b = 1'b0;

        // Single request from requester 2, one byte 0xA5.
        set_req(2, 4'd1, 8'd2, {8'hA5, 120'h0});
        push(K_GOK, 2, '0);
        push(K_DONE, 2, {8'hA5, 120'h0});
        wait_grant(2);
        req = '0;
        wait_q_empty(500);

        // Rejected requests: zero size, then baud below 2.
        tf0 = n_tf;
        set_req(1, 4'd0, 8'd2, 128'h1);
        push(K_GERR, 1, '0);
        wait_grant(1);
        req = '0;
        @(negedge clk);
        check("err_busy_fs0", busy, 1'b0);
        set_req(3, 4'd1, 8'd1, 128'h3);
        push(K_GERR, 3, '0);
        wait_grant(3);
        req = '0;
        repeat (3) @(negedge clk);
        check("err_busy_baud1", busy, 1'b0);
        check("err_no_tf", n_tf, tf0);
        wait_q_empty(50);

        // Requester scrambles its slice right after the grant.
        fb_d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        set_req(0, 4'd3, 8'd3, fb_d);
        push(K_GOK, 0, '0);
        push(K_DONE, 0, fb_d);
        wait_grant(0);
        req = '0;
        set_req(0, 4'hF, 8'hFF, ~fb_d);
        req = '0;
        wait_q_empty(500);

        // Transmitter disconnected: start timeout.
        disc = 1'b1;
        set_req(1, 4'd1, 8'd4, 128'h55);
        push(K_GOK, 1, '0);
        push(K_TMO, 1, '0);
        wait_grant(1);
        req = '0;
        wait_q_empty(100);
        disc = 1'b0;
        @(negedge clk);

        // Reset mid-frame; RECOVER must absorb the rest of the frame before any grant.
        set_req(3, 4'd15, 8'd8, {16{8'h3C}});
        push(K_GOK, 3, '0);
        wait_grant(3);
        req = '0;
        repeat (200) @(negedge clk);
        set_req(0, 4'd1, 8'd2, {8'h5A, 120'h0});
        push(K_GOK, 0, '0);
        push(K_DONE, 0, {8'h5A, 120'h0});
        @(negedge clk);
        check("midframe_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_tf", txif.tf, 1'b0);
        check("arst_framebits", txif.framebits, 128'b0);
        check("arst_done_id", done_id, 3'd0);
        check("arst_busy", busy, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        n = 0;
        while (!m_txi && n < 2000) begin
            @(negedge clk);
            if (grant != '0 || !busy) bad++;
            n++;
        end
        check("recover_hold", bad, 0);
        check("recover_tx_idle", m_txi, 1'b1);
        wait_grant(0);
        req = '0;
        wait_q_empty(500);
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Round-robin scheduler that shares one `transmitter` serial framer between `NREQ` frame sources. It captures a winning request's frame, size and baud rate into holding registers, drives them steady into the transmitter, launches it with `tf`, and tracks completion via `TXI`. It sits between the frame producers and the transmitter instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `START_TIMEOUT`, 15: cycles in LAUNCH without `TXI` falling before abort.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset; one clock, asynchronous, active-low.
- `req`  in  NREQ  per-requester request level, held until `grant` bit seen.
- `req_framesize`  in  NREQ*4  byte count per requester, slice i = [4i+3:4i].
- `req_framebits`  in  NREQ*128  frame data, slice i = [128i+127:128i], byte 0 in MSbyte.
- `req_baudrate`  in  NREQ*8  clocks per bit per requester.
- `grant`  out  NREQ  one-hot 1-cycle pulse: request i consumed (data captured).
- `err`  out  1  1-cycle pulse: rejected request, or start timeout.
- `done`  out  1  1-cycle pulse: frame fully transmitted.
- `done_id`  out  3  index of frame reported by `done`/`err`.
- `busy`  out  1  high in any state except IDLE.
- `tf`  out  1  to transmitter: start.
- `framesize`, `framebits`, `baudrate`  out  4/128/8  to transmitter, registered copies.
- `TXI`  in  1  from transmitter: 1 = idle, 0 = transmitting.

## Operation
- States: RECOVER, IDLE, LAUNCH, BUSY.
- Reset: state RECOVER; `grant`, `err`, `done`, `tf` = 0; `done_id`, `framesize`, `framebits`, `baudrate` = 0; rr pointer = 0; `busy` = 1.
- RECOVER: transmitter has no reset and may be mid-frame. Wait until `TXI`=1, then IDLE. No grants.
- IDLE: pick the first asserted `req` at or after the rr pointer (wrapping). On a pick, pulse `grant[i]`, capture slice i into the output registers, set `done_id`=i, and set pointer = i+1 mod NREQ.
  - If `req_framesize`=0 or `req_baudrate`<2: pulse `err` with `grant`, stay in IDLE, never assert `tf`.
  - Otherwise set `tf`=1 and go to LAUNCH.
- LAUNCH: hold `tf`=1.
  - When `TXI`=0 is sampled: `tf`=0, go to BUSY.
  - If `START_TIMEOUT` cycles elapse with `TXI`=1: `tf`=0, pulse `err`, go to IDLE.
- BUSY: hold the output registers unchanged, since the transmitter reads them live.
  - When `TXI`=1 is sampled: pulse `done`, go to IDLE.
- Only one frame is in flight. Requests arriving while busy wait. A `req` dropped before grant is never served.
- Simultaneous requests are arbitrated by round-robin only, with no priority.

## Timing
- All outputs are registered.
- `req[i]` sampled at edge E in IDLE:
  - `grant[i]`, `tf`=1 and the data registers are valid after E.
  - The transmitter samples `tf` at E+1, and `TXI` falls after E+1.
  - The scheduler samples `TXI`=0 at E+2, so `tf` drops after E+2.
- The transmitter raises `TXI` in its stop state. The scheduler samples it one edge later and `done` pulses for one cycle.
- The next grant is possible in the cycle after `done`, so the back-to-back gap is 1 idle cycle.
- Requesters may change their slice or drop `req` in the cycle after `grant`.
- Reset asserted mid-frame: outputs clear immediately. `tf`=0 prevents a retrigger. RECOVER then absorbs the remainder of the frame.

## Structure
- Package `tx_pkg`: state enum `tx_sched_state_t`, constants `FRAME_BYTES`=16, `FRAME_W`=128, `BAUD_W`=8, `FSIZE_W`=4.
- Sub-module `rr_picker`: combinational; inputs `req` and pointer; outputs `valid` and one-hot/index winner. Instantiated once.
- The `transmitter` is not instantiated inside. It is connected beside the scheduler at the top level, and the bench instantiates both.

## Test plan
- Single request: `req[2]`, framesize=1, baud=2, data byte 0xA5. Expect `grant`=0b0100 → `tf` for 2 cycles → `done` with `done_id`=2. TX sequence: start bit, 0001, 10100101, CRC byte, stop bit.
- All four requesting continuously, framesize=2: grants occur in order 0,1,2,3,0. Each `done` precedes the next `grant` by ≥1 cycle.
- `req[1]` framesize=0, and a separate request with baud=1: each gives `grant` + `err` in the same cycle, `tf` never rises, `busy` stays 0.
- Requester changes its data the cycle after `grant`: the transmitted bits match the captured values, and `framebits` output is stable until `done`.
- `reset_n` pulsed low mid-frame (framesize=15, baud=8): outputs clear asynchronously, `busy`=1 in RECOVER until `TXI`=1, no `grant` before that.
- `TXI` forced to 1 (transmitter disconnected): `err` pulses exactly 15 cycles after `tf` rises, then state returns to IDLE.
